// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, port ids, FSM
// states and the alignment check used at grant time.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  localparam logic PORT_M0 = 1'b0;
  localparam logic PORT_M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Illegal size, or an address not aligned to the access size.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lo);
    return (size == SZ_BAD) ||
           (size == SZ_HALF && lo[0]) ||
           (size == SZ_WORD && lo != 2'b00);
  endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two identical request ports.
// A port raises req with stable fields and holds them until gnt is seen high in
// the same cycle (gnt acts as ready); done then pulses once with rdata/err valid.
interface data_memory_arbiter_if;
  logic        m0_req,      m1_req;
  logic        m0_we,       m1_we;
  logic [1:0]  m0_size,     m1_size;
  logic        m0_unsigned, m1_unsigned;
  logic [31:0] m0_addr,     m1_addr;
  logic [31:0] m0_wdata,    m1_wdata;
  logic        m0_gnt,      m1_gnt;
  logic        m0_done,     m1_done;
  logic [31:0] m0_rdata,    m1_rdata;
  logic        m0_err,      m1_err;

  modport master (
    output m0_req, m0_we, m0_size, m0_unsigned, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_size, m1_unsigned, m1_addr, m1_wdata,
    input  m0_gnt, m0_done, m0_rdata, m0_err,
    input  m1_gnt, m1_done, m1_rdata, m1_err
  );

  modport slave (
    input  m0_req, m0_we, m0_size, m0_unsigned, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_size, m1_unsigned, m1_addr, m1_wdata,
    output m0_gnt, m0_done, m0_rdata, m0_err,
    output m1_gnt, m1_done, m1_rdata, m1_err
  );
endinterface

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane logic: load extraction with sign/zero extension and
// store merge of a byte or halfword into the word read back from memory.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] shifted;

  assign byte_sh = {lane, 3'b000};
  assign half_sh = {lane[1], 4'b0000};
  assign shifted = word >> byte_sh;

  always_comb begin
    load_data = word;
    merged    = word;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
        merged[byte_sh +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
        merged[half_sh +: 16] = wdata[15:0];
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter and access sequencer in front of the single-port data
// memory; sub-word stores are done as read-modify-write.
module data_memory_arbiter
  import dmem_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  data_memory_arbiter_if.slave       bus,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata,
  output state_t                     dbg_state
);

  state_t      state;
  logic        last;
  logic        owner;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, merged_q;
  logic        m0_done_q, m1_done_q, m0_err_q, m1_err_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;

  logic        any_req, win_m1, win_id;
  logic        sel_we, sel_uns, sel_ill;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;
  logic        fin, fin_id, fin_err;
  logic [31:0] load_data, merged;

  // m1 wins only if m0 is idle or m0 held the grant last time.
  assign any_req   = bus.m0_req | bus.m1_req;
  assign win_m1    = bus.m1_req & (~bus.m0_req | (last == PORT_M0));
  assign win_id    = win_m1 ? PORT_M1 : PORT_M0;
  assign bus.m0_gnt = (state == ST_IDLE) & bus.m0_req & ~win_m1;
  assign bus.m1_gnt = (state == ST_IDLE) & win_m1;

  assign sel_we    = win_m1 ? bus.m1_we       : bus.m0_we;
  assign sel_uns   = win_m1 ? bus.m1_unsigned : bus.m0_unsigned;
  assign sel_size  = win_m1 ? bus.m1_size     : bus.m0_size;
  assign sel_addr  = win_m1 ? bus.m1_addr     : bus.m0_addr;
  assign sel_wdata = win_m1 ? bus.m1_wdata    : bus.m0_wdata;
  assign sel_ill   = is_illegal(sel_size, sel_addr[1:0]);

  assign bus.m0_done  = m0_done_q;
  assign bus.m1_done  = m1_done_q;
  assign bus.m0_err   = m0_err_q;
  assign bus.m1_err   = m1_err_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;
  assign dbg_state    = state;

  dmem_lane_unit u_lane (
    .size        (size_q),
    .is_unsigned (uns_q),
    .lane        (addr_q[1:0]),
    .word        (mem_rdata),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  // Decides whether the FSM enters DONE on this edge and for whom.
  always_comb begin
    fin     = 1'b0;
    fin_id  = owner;
    fin_err = 1'b0;
    case (state)
      ST_IDLE: if (any_req && sel_ill) begin
        fin     = 1'b1;
        fin_id  = win_id;
        fin_err = 1'b1;
      end
      ST_ACCESS: fin = ~we_q | (size_q == SZ_WORD);
      ST_WRITE:  fin = 1'b1;
      default:   fin = 1'b0;
    endcase
  end

  // Memory side is decoded from registers only, never from req.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state)
      ST_ACCESS: begin
        mem_addr = {addr_q[31:2], 2'b00};
        if (we_q && size_q == SZ_WORD) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
        end
      end
      ST_WRITE: begin
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_we    = 1'b1;
        mem_wdata = merged_q;
      end
      default: mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last       <= PORT_M1;
      owner      <= PORT_M0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      merged_q   <= 32'h0;
      m0_done_q  <= 1'b0;
      m1_done_q  <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= 32'h0;
      m1_rdata_q <= 32'h0;
    end else begin
      m0_done_q <= fin & (fin_id == PORT_M0);
      m1_done_q <= fin & (fin_id == PORT_M1);
      m0_err_q  <= fin & (fin_id == PORT_M0) & fin_err;
      m1_err_q  <= fin & (fin_id == PORT_M1) & fin_err;
      case (state)
        ST_IDLE: if (any_req) begin
          owner   <= win_id;
          last    <= win_id;
          we_q    <= sel_we;
          uns_q   <= sel_uns;
          size_q  <= sel_size;
          addr_q  <= sel_addr;
          wdata_q <= sel_wdata;
          err_q   <= sel_ill;
          if (sel_ill) begin
            state <= ST_DONE;
            if (win_id == PORT_M1) m1_rdata_q <= 32'h0;
            else                   m0_rdata_q <= 32'h0;
          end else begin
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!we_q) begin
            if (owner == PORT_M1) m1_rdata_q <= load_data;
            else                  m0_rdata_q <= load_data;
            state <= ST_DONE;
          end else if (size_q == SZ_WORD) begin
            state <= ST_DONE;
          end else begin
            merged_q <= merged;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a byte-array memory model.
module tb_data_memory_arbiter;
  import dmem_pkg::*;

  logic        clock;
  logic        reset;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  state_t      dbg_state;

  data_memory_arbiter_if bus ();

  data_memory_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // memory model
  logic [7:0] mem [256];
  logic [7:0] ma;
  assign ma = mem_addr[7:0];
  assign mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

  int we_cnt;
  int done_cnt;
  always @(posedge clock) begin
    if (mem_we) begin
      mem[ma]        <= mem_wdata[7:0];
      mem[ma + 8'd1] <= mem_wdata[15:8];
      mem[ma + 8'd2] <= mem_wdata[23:16];
      mem[ma + 8'd3] <= mem_wdata[31:24];
      we_cnt++;
    end
    if (bus.m0_done || bus.m1_done) done_cnt++;
  end

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  task automatic set_word(input logic [7:0] a, input logic [31:0] v);
    mem[a]        = v[7:0];
    mem[a + 8'd1] = v[15:8];
    mem[a + 8'd2] = v[23:16];
    mem[a + 8'd3] = v[31:24];
  endtask

  // scoreboard
  int total;
  int bad;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] expv;
    expv = exp_q.pop_front();
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic drive_port(input int port, input logic req, input logic we,
                            input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_size = size;
      bus.m0_unsigned = uns; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_size = size;
      bus.m1_unsigned = uns; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  // Called just after a rising edge with the bus idle; returns done latency
  // in cycles after the grant cycle (0 = no done seen), plus captured results.
  task automatic access(input int port, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat,
                        output logic [31:0] rdata, output logic err, output int nwe);
    logic got;
    int   we0;
    got = 1'b0; lat = 0; rdata = 32'hx; err = 1'bx;
    we0 = we_cnt;
    drive_port(port, 1'b1, we, size, uns, addr, wdata);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      got = (port == 0) ? bus.m0_gnt : bus.m1_gnt;
      @(posedge clock); #1;
    end
    drive_port(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(32'd1);
    check("grant_seen", {31'd0, got});
    if (got) begin
      for (int k = 1; k <= 10 && lat == 0; k++) begin
        @(negedge clock);
        if ((port == 0) ? bus.m0_done : bus.m1_done) begin
          lat   = k;
          rdata = (port == 0) ? bus.m0_rdata : bus.m1_rdata;
          err   = (port == 0) ? bus.m0_err : bus.m1_err;
        end
        @(posedge clock); #1;
      end
    end
    nwe = we_cnt - we0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  int          lat, nwe, d0, w0, ngr;
  logic [31:0] rd;
  logic        er;
  int          gid[4];
  int          gcyc[4];
  logic        both_gnt;

  initial begin
    total = 0; bad = 0; we_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b0;
    drive_port(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive_port(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);

    // reset state
    exp_q.push_back(32'h0); check("rst_mem_we", {31'd0, mem_we});
    exp_q.push_back(32'h0); check("rst_mem_addr", mem_addr);
    exp_q.push_back(32'h0); check("rst_mem_wdata", mem_wdata);
    exp_q.push_back(32'h0); check("rst_outs",
      {26'd0, bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err});
    exp_q.push_back(32'h0); check("rst_m0_rdata", bus.m0_rdata);
    exp_q.push_back(32'h0); check("rst_m1_rdata", bus.m1_rdata);
    exp_q.push_back(32'(ST_IDLE)); check("rst_state", 32'(dbg_state));
    reset = 1'b1;
    @(posedge clock); #1;

    // word store then load on m0
    access(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, nwe);
    exp_q.push_back(32'd2); check("wst_lat", 32'(lat));
    exp_q.push_back(32'd1); check("wst_nwe", 32'(nwe));
    exp_q.push_back(32'h0); check("wst_err", {31'd0, er});
    exp_q.push_back(32'hDEADBEEF); check("wst_mem", mem_word(8'h10));
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, er, nwe);
    exp_q.push_back(32'd2); check("wld_lat", 32'(lat));
    exp_q.push_back(32'hDEADBEEF); check("wld_rdata", rd);
    exp_q.push_back(32'h0); check("wld_err", {31'd0, er});
    exp_q.push_back(32'd0); check("wld_nwe", 32'(nwe));

    // byte store read-modify-write on m1
    set_word(8'h20, 32'h11223344);
    access(1, 1'b1, SZ_BYTE, 1'b0, 32'h22, 32'h000000AA, lat, rd, er, nwe);
    exp_q.push_back(32'd3); check("bst_lat", 32'(lat));
    exp_q.push_back(32'd1); check("bst_nwe", 32'(nwe));
    exp_q.push_back(32'h11AA3344); check("bst_mem", mem_word(8'h20));

    // half store into upper lane
    set_word(8'h24, 32'hA5A5A5A5);
    access(0, 1'b1, SZ_HALF, 1'b0, 32'h26, 32'hFFFF1234, lat, rd, er, nwe);
    exp_q.push_back(32'd3); check("hst_lat", 32'(lat));
    exp_q.push_back(32'h1234A5A5); check("hst_mem", mem_word(8'h24));

    // sign / zero extension
    set_word(8'h30, 32'h80F07F01);
    access(0, 1'b0, SZ_BYTE, 1'b0, 32'h32, 32'h0, lat, rd, er, nwe);
    exp_q.push_back(32'hFFFFFFF0); check("ld_sb_32", rd);
    access(1, 1'b0, SZ_HALF, 1'b1, 32'h32, 32'h0, lat, rd, er, nwe);
    exp_q.push_back(32'h000080F0); check("ld_uh_32", rd);
    access(0, 1'b0, SZ_BYTE, 1'b0, 32'h30, 32'h0, lat, rd, er, nwe);
    exp_q.push_back(32'h00000001); check("ld_sb_30", rd);
    access(1, 1'b0, SZ_HALF, 1'b0, 32'h32, 32'h0, lat, rd, er, nwe);
    exp_q.push_back(32'hFFFF80F0); check("ld_sh_32", rd);
    access(0, 1'b0, SZ_BYTE, 1'b1, 32'h33, 32'h0, lat, rd, er, nwe);
    exp_q.push_back(32'h00000080); check("ld_ub_33", rd);
    access(1, 1'b0, SZ_HALF, 1'b0, 32'h30, 32'h0, lat, rd, er, nwe);
    exp_q.push_back(32'h00007F01); check("ld_sh_30", rd);

    // misalignment and illegal size
    set_word(8'h40, 32'hCAFEF00D);
    access(0, 1'b0, SZ_HALF, 1'b0, 32'h41, 32'h0, lat, rd, er, nwe);
    exp_q.push_back(32'd1); check("mis_h_lat", 32'(lat));
    exp_q.push_back(32'h1); check("mis_h_err", {31'd0, er});
    exp_q.push_back(32'h0); check("mis_h_rdata", rd);
    exp_q.push_back(32'd0); check("mis_h_nwe", 32'(nwe));
    access(1, 1'b1, SZ_WORD, 1'b0, 32'h42, 32'h12345678, lat, rd, er, nwe);
    exp_q.push_back(32'd1); check("mis_w_lat", 32'(lat));
    exp_q.push_back(32'h1); check("mis_w_err", {31'd0, er});
    exp_q.push_back(32'd0); check("mis_w_nwe", 32'(nwe));
    exp_q.push_back(32'hCAFEF00D); check("mis_w_mem", mem_word(8'h40));
    access(1, 1'b1, SZ_BAD, 1'b0, 32'h40, 32'h12345678, lat, rd, er, nwe);
    exp_q.push_back(32'h1); check("bad_sz_err", {31'd0, er});
    exp_q.push_back(32'hCAFEF00D); check("bad_sz_mem", mem_word(8'h40));

    // round-robin with both requesting from reset
    pulse_reset();
    ngr = 0; both_gnt = 1'b0;
    drive_port(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0);
    drive_port(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 40 && ngr < 4; c++) begin
      @(negedge clock);
      if (bus.m0_gnt && bus.m1_gnt) both_gnt = 1'b1;
      if (bus.m0_gnt || bus.m1_gnt) begin
        gid[ngr]  = bus.m1_gnt ? 1 : 0;
        gcyc[ngr] = c;
        ngr++;
      end
      @(posedge clock); #1;
    end
    drive_port(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive_port(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(32'd4); check("rr_count", 32'(ngr));
    exp_q.push_back(32'h0); check("rr_both", {31'd0, both_gnt});
    if (ngr == 4) begin
      exp_q.push_back(32'b0101); check("rr_order",
        {28'd0, gid[0][0], gid[1][0], gid[2][0], gid[3][0]});
      exp_q.push_back(32'd3); check("rr_gap1", 32'(gcyc[1] - gcyc[0]));
      exp_q.push_back(32'd3); check("rr_gap3", 32'(gcyc[3] - gcyc[2]));
    end
    exp_q.push_back(32'hDEADBEEF); check("rr_m1_rdata", bus.m1_rdata);
    repeat (4) @(posedge clock); #1;

    // reset during ACCESS of a byte store
    set_word(8'h50, 32'h55667788);
    drive_port(0, 1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h51, 32'h00000099);
    @(negedge clock);
    exp_q.push_back(32'h1); check("rst_acc_gnt", {31'd0, bus.m0_gnt});
    @(posedge clock); #1;
    drive_port(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(32'(ST_ACCESS)); check("rst_acc_state", 32'(dbg_state));
    d0 = done_cnt; w0 = we_cnt;
    reset = 1'b0;
    #1;
    exp_q.push_back(32'(ST_IDLE)); check("rst_acc_idle", 32'(dbg_state));
    exp_q.push_back(32'h0); check("rst_acc_we", {31'd0, mem_we});
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(posedge clock); #1;
    exp_q.push_back(32'(d0)); check("rst_acc_done", 32'(done_cnt));
    exp_q.push_back(32'(w0)); check("rst_acc_nwe", 32'(we_cnt));
    exp_q.push_back(32'h55667788); check("rst_acc_mem", mem_word(8'h50));

    // first tie after reset goes to m0
    drive_port(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h50, 32'h0);
    drive_port(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
    @(negedge clock);
    exp_q.push_back(32'b10); check("post_rst_tie", {30'd0, bus.m0_gnt, bus.m1_gnt});
    @(posedge clock); #1;
    drive_port(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive_port(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (4) @(posedge clock); #1;
    exp_q.push_back(32'h55667788); check("post_rst_ld", bus.m0_rdata);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter and access sequencer in front of the single-port, byte-addressed data memory. It shares the memory between the core load/store path (m0) and the loader/debug port (m1) with round-robin arbitration. It also handles all memory-side timing: byte and halfword loads with sign or zero extension, byte and halfword stores by read-modify-write, and reporting of misaligned accesses. It sits between the pipeline MEM stage / loader and the data memory, which reads combinationally and writes 32 bits at A..A+3 on the clock edge.

## Interface
- No parameters; address and data are fixed at 32 bits.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 = reset
- m0_req / m1_req  in  1  access request; held high with fields stable until the matching gnt
- m0_we / m1_we  in  1  1 = store, 0 = load
- m0_size / m1_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- m0_unsigned / m1_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  store data; the low 8 or 16 bits are used for sub-word stores
- m0_gnt / m1_gnt  out  1  combinational; request accepted this cycle (IDLE only)
- m0_done / m1_done  out  1  registered one-cycle completion pulse
- m0_rdata / m1_rdata  out  32  load result; valid while done is high, and held until that port's next done
- m0_err / m1_err  out  1  valid with done; misaligned address or illegal size
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned memory address (addr & ~3)
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data (combinational from mem_addr)

## Operation
- **States:** IDLE, ACCESS, WRITE, DONE.
- **IDLE, arbitration**
  - If exactly one request is high, that port wins.
  - If both are high, the port that was not granted last wins.
  - The pointer resets to "m1 last", so m0 wins the first tie.
  - The winner's gnt is high this cycle. On the clock edge the winner's id, we, size, unsigned, addr and wdata are latched and the pointer is updated.
  - Next state: DONE if the request is illegal, otherwise ACCESS.
- **Illegal request:** size 11, half with addr[0]=1, or word with addr[1:0]≠0. The memory is never touched; err=1 and rdata=0 at done.
- **ACCESS:** mem_addr = latched addr & ~3. lane = addr[1:0].
  - Load: extract the byte at mem_rdata[8*lane+:8] or the half at mem_rdata[8*lane+:16], extend per unsigned, register into the owner's rdata. Next state DONE.
  - Word store: mem_we=1, mem_wdata=wdata. Next state DONE.
  - Sub-word store: merge wdata into the selected lane of mem_rdata and keep the other bytes; register the result. Next state WRITE.
- **WRITE:** mem_we=1, mem_wdata = merged word. Next state DONE.
- **DONE:** the owner's done is high for one cycle. Next state IDLE.
- **Memory outputs:** mem_we is decoded from the state. mem_addr and mem_wdata are 0 in IDLE and DONE.
- **Reset values:** all outputs 0, state IDLE, both rdata registers 0.
- **Reset mid-operation:** asynchronous entry to IDLE.
  - mem_we drops immediately.
  - A read-modify-write interrupted in ACCESS issues no write.
  - No done is emitted for the aborted access.
- **Request dropped before gnt:** ignored; no state change.
- **Request while busy:** no gnt, except in IDLE. The requester waits.

## Timing
- The gnt cycle is T.
  - Load or word store: done at T+2.
  - Sub-word store: memory write at T+2, done at T+3.
  - Illegal request: done at T+1.
- Minimum spacing between grants is 3 cycles (load or word store) or 4 cycles (sub-word store).
- A request held through DONE is granted in the following IDLE cycle.
- No combinational path from the m*_req inputs to the mem_* outputs.

## Structure
- **Package `dmem_pkg`:** size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, port-id constants.
- **Sub-module `dmem_lane_unit`:** purely combinational. Load path: extract and extend. Store path: lane merge. It is instantiated once; the FSM, arbitration pointer and per-port registers stay in the top module.

## Test plan
- Word store then load on m0: store 0xDEADBEEF to 0x10, then load word 0x10 → mem_we pulses once; m0_rdata=0xDEADBEEF at T+2; err=0.
- Byte store read-modify-write: memory[0x20]=0x11223344; m1 byte store 0xAA to 0x22 → memory word becomes 0x11AA3344; done at T+3; exactly one mem_we cycle.
- Sign and zero extension: word 0x80F0_7F01 at 0x30.
  - Signed byte load at 0x32 → 0xFFFFFFF0.
  - Unsigned half load at 0x32 → 0x000080F0.
  - Signed byte load at 0x30 → 0x00000001.
- Round-robin: both requesting continuously after reset → grants alternate m0, m1, m0, m1; no port is granted twice in a row while the other waits.
- Misalignment: half load at 0x41, and word store at 0x42 → err=1 and done at T+1, mem_we never asserted, memory unchanged.
- Reset in ACCESS of a byte store → mem_we stays 0, no done, target word unchanged; the first post-reset tie goes to m0.
